// File: rtl/core5_shared_mem_arbiter_if.sv
// Bus bundle between NUM_REQ Avalon-MM data masters, the shared-RAM arbiter
// and the single-port RAM behind it.
interface core5_shared_mem_arbiter_if #(
    parameter int NUM_REQ = 5,
    parameter int ADDR_W  = 14
);
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*4-1:0]      req_byteenable;
    logic [NUM_REQ-1:0]        req_read;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*32-1:0]     req_writedata;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        req_waitrequest;
    logic [31:0]               req_readdata;
    logic [NUM_REQ-1:0]        req_readdatavalid;
    logic [ADDR_W-1:0]         ram_address;
    logic [3:0]                ram_byteenable;
    logic                      ram_chipselect;
    logic                      ram_write;
    logic [31:0]               ram_writedata;
    logic                      ram_clken;
    logic [31:0]               ram_readdata;

    modport slave (
        input  req_address, req_byteenable, req_read, req_write, req_writedata, req_lock,
        input  ram_readdata,
        output req_waitrequest, req_readdata, req_readdatavalid,
        output ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken
    );

    modport master (
        output req_address, req_byteenable, req_read, req_write, req_writedata, req_lock,
        output ram_readdata,
        input  req_waitrequest, req_readdata, req_readdatavalid,
        input  ram_address, ram_byteenable, ram_chipselect, ram_write, ram_writedata, ram_clken
    );
endinterface

// File: rtl/core5_shared_mem_arbiter.sv
// Round-robin arbiter granting one master per cycle onto the shared single-port RAM,
// with an optional bounded lock for atomic read-modify-write sequences.
module core5_shared_mem_arbiter #(
    parameter int NUM_REQ  = 5,
    parameter int ADDR_W   = 14,
    parameter int LOCK_MAX = 16
) (
    input  logic clk,
    input  logic reset,
    core5_shared_mem_arbiter_if.slave bus
);
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW     = IDX_W + 1;
    localparam int HOLD_W = $clog2(LOCK_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;

    state_t            r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_last, w_last_nxt;
    logic [IDX_W-1:0]  r_owner, w_owner_nxt;
    logic [IDX_W-1:0]  r_rd_id, w_rd_id_nxt;
    logic [IDX_W-1:0]  w_win;
    logic [CW-1:0]     w_cand;
    logic [HOLD_W-1:0] r_hold, w_hold_nxt, w_hold_inc;
    logic              r_rd_pend, w_rd_pend_nxt;
    logic              w_found;
    logic [NUM_REQ-1:0] w_active, w_grant, w_rvalid;
    logic [ADDR_W-1:0] w_ram_address;
    logic [3:0]        w_ram_byteenable;
    logic [31:0]       w_ram_writedata;
    logic              w_ram_write;

    assign w_active   = bus.req_read | bus.req_write;
    assign w_hold_inc = r_hold + HOLD_W'(1);

    // Winner selection: locked owner only, else first active after last_grant
    always_comb begin
        w_found = 1'b0;
        w_win   = {IDX_W{1'b0}};
        w_cand  = {CW{1'b0}};
        if (reset) begin
            w_found = 1'b0;
        end else if (r_state == ST_LOCKED) begin
            w_found = w_active[r_owner];
            w_win   = r_owner;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                w_cand = {1'b0, r_last} + CW'(k);
                if (w_cand >= CW'(NUM_REQ)) begin
                    w_cand = w_cand - CW'(NUM_REQ);
                end else begin
                    w_cand = w_cand;
                end
                if (!w_found && w_active[w_cand[IDX_W-1:0]]) begin
                    w_found = 1'b1;
                    w_win   = w_cand[IDX_W-1:0];
                end else begin
                    w_found = w_found;
                end
            end
        end
    end

    // Grant vector and RAM-side mux of the winning master
    always_comb begin
        w_grant          = {NUM_REQ{1'b0}};
        w_ram_address    = {ADDR_W{1'b0}};
        w_ram_byteenable = 4'h0;
        w_ram_writedata  = 32'h0;
        w_ram_write      = 1'b0;
        if (w_found) begin
            w_grant[w_win]   = 1'b1;
            w_ram_address    = bus.req_address[w_win*ADDR_W +: ADDR_W];
            w_ram_byteenable = bus.req_byteenable[w_win*4 +: 4];
            w_ram_writedata  = bus.req_writedata[w_win*32 +: 32];
            w_ram_write      = bus.req_write[w_win];
        end else begin
            w_grant = {NUM_REQ{1'b0}};
        end
    end

    // Read-return strobe for the access issued last cycle; suppressed in reset
    always_comb begin
        w_rvalid = {NUM_REQ{1'b0}};
        if (r_rd_pend && !reset) begin
            w_rvalid[r_rd_id] = 1'b1;
        end else begin
            w_rvalid = {NUM_REQ{1'b0}};
        end
    end

    // Next-state: arbitration/lock FSM, round-robin pointer and pending read
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_hold_nxt    = r_hold;
        w_last_nxt    = r_last;
        w_rd_pend_nxt = w_found && !bus.req_write[w_win];
        w_rd_id_nxt   = w_win;
        case (r_state)
            ST_ARB: begin
                if (w_found) begin
                    w_last_nxt = w_win;
                    if (bus.req_lock[w_win]) begin
                        w_state_nxt = ST_LOCKED;
                        w_owner_nxt = w_win;
                        w_hold_nxt  = HOLD_W'(1);
                    end else begin
                        w_state_nxt = ST_ARB;
                    end
                end else begin
                    w_last_nxt = r_last;
                end
            end
            ST_LOCKED: begin
                // Owner drops to lowest priority once the lock ends
                if (!bus.req_lock[r_owner] || (w_hold_inc >= HOLD_W'(LOCK_MAX))) begin
                    w_state_nxt = ST_ARB;
                    w_hold_nxt  = {HOLD_W{1'b0}};
                    w_last_nxt  = r_owner;
                end else begin
                    w_hold_nxt  = w_hold_inc;
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
                w_hold_nxt  = {HOLD_W{1'b0}};
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_ARB;
            r_last    <= LAST_RST;
            r_owner   <= {IDX_W{1'b0}};
            r_hold    <= {HOLD_W{1'b0}};
            r_rd_pend <= 1'b0;
            r_rd_id   <= {IDX_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_last    <= w_last_nxt;
            r_owner   <= w_owner_nxt;
            r_hold    <= w_hold_nxt;
            r_rd_pend <= w_rd_pend_nxt;
            r_rd_id   <= w_rd_id_nxt;
        end
    end

    assign bus.req_waitrequest   = w_active & ~w_grant;
    assign bus.req_readdata      = bus.ram_readdata;
    assign bus.req_readdatavalid = w_rvalid;
    assign bus.ram_address       = w_ram_address;
    assign bus.ram_byteenable    = w_ram_byteenable;
    assign bus.ram_chipselect    = w_found;
    assign bus.ram_write         = w_ram_write;
    assign bus.ram_writedata     = w_ram_writedata;
    assign bus.ram_clken         = 1'b1;
endmodule
